// File: rtl/fwd_pkg.sv
// Shared types and encodings for the EX-stage forwarding / hazard unit.
// Slot records describe the producer held in each downstream stage.
package fwd_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_WB    = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    // Destination side of an in-flight instruction.
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  regwrite;
    } dst_t;

    // Pipe slot: destination plus the load flag.
    typedef struct packed {
        dst_t dst;
        logic memread;
    } slot_t;

    // A producer matches a source only if it is real, writes, and is not x0.
    function automatic logic dst_hit(
        input dst_t                  d,
        input logic [REG_AW_DEF-1:0] rs
    );
        return d.valid & d.regwrite & (d.rd != '0) & (d.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority comparator for one EX operand: the newest producer wins.
// A load sitting in EX is never a forwarding source.
module fwd_sel_calc
    import fwd_pkg::*;
(
    input  logic [REG_AW_DEF-1:0] i_rs,
    input  logic                  i_use,
    input  slot_t                 i_ex,
    input  dst_t                  i_mem,
    output logic [1:0]            o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_use & dst_hit(i_ex.dst, i_rs) & ~i_ex.memread;
    assign w_mem_hit = i_use & dst_hit(i_mem, i_rs);

    // Pick the source for this operand, EX/MEM before WB.
    always_comb begin
        o_sel = SEL_RF;
        if (w_ex_hit) begin
            o_sel = SEL_EXMEM;
        end else if (w_mem_hit) begin
            o_sel = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall control between ID and EX.
// Tracks the EX and MEM producers; WB is covered by write-before-read.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    if (REG_AW != REG_AW_DEF) begin : g_aw_chk
        $error("REG_AW must equal fwd_pkg::REG_AW_DEF");
    end

    slot_t             r_ex;
    dst_t              r_mem;
    logic [1:0]        r_sel_a;
    logic [1:0]        r_sel_b;
    logic [CNT_W-1:0]  r_stall_cnt;

    slot_t             w_id;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;
    logic              w_ld_use;
    logic              w_stall;

    assign w_id.dst.valid    = id_valid;
    assign w_id.dst.rd       = id_rd;
    assign w_id.dst.regwrite = id_regwrite;
    assign w_id.memread      = id_memread;

    assign w_ld_use = r_ex.memread &
                      ((id_use_rs1 & dst_hit(r_ex.dst, id_rs1)) |
                       (id_use_rs2 & dst_hit(r_ex.dst, id_rs2)));

    // A taken branch kills the consumer, so it never waits.
    assign w_stall = id_valid & w_ld_use & ~flush;

    fwd_sel_calc u_sel_a (
        .i_rs  (id_rs1),
        .i_use (id_use_rs1),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_a)
    );

    fwd_sel_calc u_sel_b (
        .i_rs  (id_rs2),
        .i_use (id_use_rs2),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_b)
    );

    // Advance the tracking slots; EX takes ID or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_sel_a <= SEL_RF;
            r_sel_b <= SEL_RF;
        end else begin
            r_mem <= r_ex.dst;
            if (flush || w_stall) begin
                r_ex    <= '0;
                r_sel_a <= SEL_RF;
                r_sel_b <= SEL_RF;
            end else begin
                r_ex    <= w_id;
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end
        end
    end

    // Count load-use stall cycles, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall     = w_stall;
    assign ex_valid  = r_ex.dst.valid;
    assign sel_a     = r_sel_a;
    assign sel_b     = r_sel_b;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed table,
// reset sequences and random traffic against an in-flight list model.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_regwrite = 1'b0;
    logic          id_memread = 1'b0;
    logic          flush = 1'b0;
    logic          stall;
    logic          ex_valid;
    logic [1:0]    sel_a;
    logic [1:0]    sel_b;
    logic [CW-1:0] stall_cnt;

    fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int v, rs1, rs2, u1, u2, rd, rw, mr, fl;
        int e_st, e_exv, e_sa, e_sb, e_cnt;
    } vec_t;

    // In-flight instruction as the model sees it.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    // pipe[0] is the instruction in EX, pipe[1] the one in MEM.
    ins_t    pipe[$];
    int      m_sa, m_sb, m_exv;
    longint  m_cnt;

    task automatic chk(input string nm, input logic [63:0] act,
                       input longint exp);
        n_tests++;
        if (act !== 64'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ins_t b = '{0, 0, 0, 0};
        pipe = {b, b};
        m_sa = 0;
        m_sb = 0;
        m_exv = 0;
        m_cnt = 0;
    endfunction

    function automatic bit writes(input ins_t p, input int rs);
        return p.v && p.rw && p.rd != 0 && p.rd == rs;
    endfunction

    function automatic bit model_stall();
        bit dep;
        dep = (id_use_rs1 && writes(pipe[0], int'(id_rs1))) ||
              (id_use_rs2 && writes(pipe[0], int'(id_rs2)));
        return id_valid && !flush && pipe[0].mr && dep;
    endfunction

    function automatic int fwd_code(input int rs, input bit u);
        if (!u) return 0;
        if (writes(pipe[0], rs) && !pipe[0].mr) return 2;
        if (writes(pipe[1], rs)) return 1;
        return 0;
    endfunction

    function automatic void model_advance(input bit st);
        ins_t nw;
        int   sa, sb;
        sa = fwd_code(int'(id_rs1), id_use_rs1);
        sb = fwd_code(int'(id_rs2), id_use_rs2);
        if (flush || st) begin
            nw = '{0, 0, 0, 0};
            sa = 0;
            sb = 0;
        end else begin
            nw = '{id_valid, int'(id_rd), id_regwrite, id_memread};
        end
        if (st && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        pipe.push_front(nw);
        while (pipe.size() > 2) void'(pipe.pop_back());
        m_sa = sa;
        m_sb = sb;
        m_exv = int'(nw.v);
    endfunction

    function automatic vec_t mk(
        int v, int rs1, int rs2, int u1, int u2, int rd, int rw,
        int mr, int fl, int st, int exv, int sa, int sb, int cnt);
        vec_t r;
        r = '{v, rs1, rs2, u1, u2, rd, rw, mr, fl,
              st, exv, sa, sb, cnt};
        return r;
    endfunction

    task automatic drive(input vec_t s);
        id_valid    = s.v[0];
        id_rs1      = AW'(s.rs1);
        id_rs2      = AW'(s.rs2);
        id_use_rs1  = s.u1[0];
        id_use_rs2  = s.u2[0];
        id_rd       = AW'(s.rd);
        id_regwrite = s.rw[0];
        id_memread  = s.mr[0];
        flush       = s.fl[0];
    endtask

    // Called just after a rising edge; returns there one cycle later.
    task automatic step(input vec_t s, input bit tbl, output bit st);
        drive(s);
        #3;
        st = model_stall();
        chk("stall", stall, tbl ? s.e_st : int'(st));
        @(posedge clk);
        model_advance(st);
        #1;
        chk("ex_valid", ex_valid, tbl ? s.e_exv : m_exv);
        chk("sel_a", sel_a, tbl ? s.e_sa : m_sa);
        chk("sel_b", sel_b, tbl ? s.e_sb : m_sb);
        chk("stall_cnt", stall_cnt, tbl ? longint'(s.e_cnt) : m_cnt);
    endtask

    vec_t tbl[18];
    vec_t cur;
    vec_t idle;
    bit   st;

    initial begin
        // v rs1 rs2 u1 u2 rd rw mr fl | st exv sa sb cnt
        tbl[0]  = mk(1, 1, 2, 1, 1,  5, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 5, 6, 1, 1, 10, 1, 0, 0, 0, 1, 2, 0, 0);
        tbl[2]  = mk(1, 1, 2, 1, 1,  7, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 3, 4, 1, 1, 11, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 1, 7, 1, 1, 12, 1, 0, 0, 0, 1, 0, 1, 0);
        tbl[5]  = mk(1, 1, 2, 1, 1,  9, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 3, 4, 1, 1,  9, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[7]  = mk(1, 9, 9, 1, 1, 13, 1, 0, 0, 0, 1, 2, 2, 0);
        tbl[8]  = mk(1, 1, 2, 1, 0,  3, 1, 1, 0, 0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 3, 4, 1, 1, 14, 1, 0, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(1, 3, 4, 1, 1, 14, 1, 0, 0, 0, 1, 1, 0, 1);
        tbl[11] = mk(1, 1, 2, 1, 1,  0, 1, 0, 0, 0, 1, 0, 0, 1);
        tbl[12] = mk(1, 0, 0, 1, 1, 15, 1, 0, 0, 0, 1, 0, 0, 1);
        tbl[13] = mk(1, 1, 2, 1, 1,  0, 1, 1, 0, 0, 1, 0, 0, 1);
        tbl[14] = mk(1, 0, 0, 1, 1, 16, 1, 0, 0, 0, 1, 0, 0, 1);
        tbl[15] = mk(1, 1, 2, 1, 0,  3, 1, 1, 0, 0, 1, 0, 0, 1);
        tbl[16] = mk(1, 3, 4, 1, 1, 17, 1, 0, 1, 0, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle    = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);

        model_reset();
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_cnt", stall_cnt, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], 1'b1, st);

        // Asynchronous reset with live forwarding state.
        step(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, st);
        step(mk(1, 5, 5, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, st);
        chk("pre_rst_sel_a", sel_a, 2);
        chk("pre_rst_sel_b", sel_b, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_sel_a", sel_a, 0);
        chk("arst_sel_b", sel_b, 0);
        chk("arst_cnt", stall_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A pending load-use stall drops as soon as reset asserts.
        step(mk(1, 1, 2, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, st);
        drive(mk(1, 3, 4, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic; a stalled ID instruction is held and retried.
        st = 1'b0;
        cur = idle;
        for (int n = 0; n < 3000; n++) begin
            if (!st) begin
                cur.v  = ($urandom_range(0, 9) < 8) ? 1 : 0;
                cur.rs1 = $urandom_range(0, 3);
                cur.rs2 = $urandom_range(0, 3);
                cur.u1 = $urandom_range(0, 1);
                cur.u2 = $urandom_range(0, 1);
                cur.rd = $urandom_range(0, 3);
                cur.rw = $urandom_range(0, 1);
                cur.mr = ($urandom_range(0, 9) < 3) ? 1 : 0;
            end
            cur.fl = ($urandom_range(0, 9) == 0) ? 1 : 0;
            step(cur, 1'b0, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
